// File: rtl/rf_black_widow_muldiv.sv
// rf_black_widow_muldiv: iterative radix-2 multiply/divide unit with tagged
// request/result handshake, divide fast paths and flush.
`default_nettype none

module rf_black_widow_muldiv #(
    parameter int WID  = 80,
    parameter int TAGW = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [WID-1:0]  a_i,
    input  logic [WID-1:0]  b_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [WID-1:0]  res_o,
    output logic [TAGW-1:0] tag_o,
    output logic            dbz_o
);

    localparam logic [2:0] c_OP_MUL   = 3'd0;
    localparam logic [2:0] c_OP_MULH  = 3'd1;
    localparam logic [2:0] c_OP_MULHU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_REM   = 3'd5;
    localparam logic [2:0] c_OP_REMU  = 3'd6;
    localparam logic [2:0] c_OP_RSVD  = 3'd7;
    localparam logic [WID-1:0] c_CNT_INIT = WID'(WID - 1);
    localparam logic [WID-1:0] c_MOST_NEG = {1'b1, {(WID-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            neg_q, neg_d;
    logic            fix_q, fix_d;
    logic            dbz_q, dbz_d;
    logic [WID-1:0]  cnt_q, cnt_d;
    logic [WID-1:0]  hi_q, hi_d;
    logic [WID-1:0]  lo_q, lo_d;
    logic [WID-1:0]  mag_q, mag_d;
    logic [WID-1:0]  res_q, res_d;

    logic            w_accept;
    logic            w_is_div_i, w_signed_i, w_ovf_i, w_div_q;
    logic [WID-1:0]  w_a_mag, w_b_mag;
    logic [WID:0]    w_sum, w_rsh, w_diff;

    assign w_accept    = req_valid_i && (state_q == S_IDLE) && !flush_i;
    assign req_ready_o = (state_q == S_IDLE) && !flush_i && rst_ni;
    assign res_valid_o = (state_q == S_DONE);
    assign res_o       = res_q;
    assign tag_o       = tag_q;
    assign dbz_o       = dbz_q;

    assign w_is_div_i = (op_i >= c_OP_DIV) && (op_i <= c_OP_REMU);
    assign w_div_q    = (op_q >= c_OP_DIV) && (op_q <= c_OP_REMU);
    assign w_signed_i = (op_i == c_OP_MULH) || (op_i == c_OP_DIV) || (op_i == c_OP_REM);
    assign w_a_mag    = (w_signed_i && a_i[WID-1]) ? -a_i : a_i;
    assign w_b_mag    = (w_signed_i && b_i[WID-1]) ? -b_i : b_i;
    assign w_ovf_i    = ((op_i == c_OP_DIV) || (op_i == c_OP_REM)) &&
                        (a_i == c_MOST_NEG) && (b_i == '1);

    // Multiply: {hi,lo} shifts right, lo holds the unconsumed multiplier bits.
    assign w_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : {(WID+1){1'b0}});
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign w_rsh  = {hi_q, lo_q[WID-1]};
    assign w_diff = w_rsh - {1'b0, mag_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        neg_d   = neg_q;
        fix_d   = fix_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mag_d   = mag_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d  = op_i;
                    tag_d = tag_i;
                    dbz_d = 1'b0;
                    if (op_i == c_OP_RSVD) begin
                        res_d   = '0;
                        state_d = S_DONE;
                    end else if (w_is_div_i && (b_i == '0)) begin
                        res_d   = ((op_i == c_OP_DIV) || (op_i == c_OP_DIVU)) ? '1 : a_i;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (w_ovf_i) begin
                        res_d   = (op_i == c_OP_DIV) ? a_i : '0;
                        state_d = S_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = w_is_div_i ? w_a_mag : w_b_mag;
                        mag_d   = w_is_div_i ? w_b_mag : w_a_mag;
                        neg_d   = (op_i == c_OP_REM) ? a_i[WID-1] :
                                  ((op_i == c_OP_MULH) || (op_i == c_OP_DIV)) ?
                                  (a_i[WID-1] ^ b_i[WID-1]) : 1'b0;
                        cnt_d   = c_CNT_INIT;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (w_div_q) begin
                    if (!w_diff[WID]) begin
                        hi_d = w_diff[WID-1:0];
                        lo_d = {lo_q[WID-2:0], 1'b1};
                    end else begin
                        hi_d = w_rsh[WID-1:0];
                        lo_d = {lo_q[WID-2:0], 1'b0};
                    end
                end else begin
                    hi_d = w_sum[WID:1];
                    lo_d = {w_sum[0], lo_q[WID-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    fix_d   = 1'b0;
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                // First cycle negates the full-width result, second selects the half.
                if (!fix_q) begin
                    fix_d = 1'b1;
                    if (neg_q) begin
                        if (w_div_q) begin
                            hi_d = -hi_q;
                            lo_d = -lo_q;
                        end else begin
                            {hi_d, lo_d} = -{hi_q, lo_q};
                        end
                    end
                end else begin
                    case (op_q)
                        c_OP_MUL:   res_d = lo_q;
                        c_OP_MULH:  res_d = hi_q;
                        c_OP_MULHU: res_d = hi_q;
                        c_OP_DIV:   res_d = lo_q;
                        c_OP_DIVU:  res_d = lo_q;
                        default:    res_d = hi_q;
                    endcase
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
            dbz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            neg_q   <= 1'b0;
            fix_q   <= 1'b0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            neg_q   <= neg_d;
            fix_q   <= fix_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mag_q   <= mag_d;
            res_q   <= res_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/rf_black_widow_muldiv.md
RF_BLACK_WIDOW_MULDIV -- requirements
Module: rf_black_widow_muldiv

Interface
REQ-001 Parameter WID, default 80, operand and result width in bits; legal range 8..128.
REQ-002 Parameter TAGW, default 6, width of the request tag carried through to the result.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous and active-low.
REQ-005 flush_i  in  1  abort any in-flight or pending operation.
REQ-006 req_valid_i  in  1  request present.
REQ-007 req_ready_o  out  1  unit can accept a request.
REQ-008 op_i  in  3  operation: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved.
REQ-009 a_i, b_i  in  WID each  operands (a is dividend or multiplicand).
REQ-010 tag_i  in  TAGW  request tag.
REQ-011 res_valid_o  out  1  result present.
REQ-012 res_ready_i  in  1  consumer takes the result.
REQ-013 res_o  out  WID  result value.
REQ-014 tag_o  out  TAGW  tag of the request that produced res_o.
REQ-015 dbz_o  out  1  divide-by-zero flag, qualified by res_valid_o.

Function
REQ-016 The FSM SHALL have four states: IDLE, CALC, FIXUP and DONE.
REQ-017 req_ready_o SHALL be 1 only in IDLE; a request is accepted on any edge where req_valid_i and req_ready_o are both 1.
REQ-018 On accept, the unit SHALL register op, tag and operand magnitudes, record the result sign, load a WID-bit step counter with WID-1, and go to CALC.
- Signed operations: MULH, DIV and REM.
- Result sign: MULH and DIV use sign(a) XOR sign(b); REM uses sign(a).
REQ-019 In CALC, one radix-2 step SHALL be performed per cycle:
- Multiply: shift-add into a 2*WID accumulator.
- Divide: restoring shift-subtract, producing one quotient bit per cycle.
REQ-020 CALC SHALL last exactly WID cycles and then go to FIXUP.
REQ-021 FIXUP SHALL apply sign correction (two's complement negate), select the result half and go to DONE.
- MUL returns product[WID-1:0].
- MULH and MULHU return product[2*WID-1:WID].
- DIV and DIVU return the quotient; REM and REMU return the remainder.
REQ-022 Result latency SHALL be WID+2 cycles: res_valid_o rises on the (WID+2)th edge after the accept edge.
REQ-023 Fast paths go straight from accept to DONE on the next edge (res_valid_o one cycle after accept):
- Divide ops with b_i==0: DIV/DIVU give all ones, REM/REMU give a_i, dbz_o=1.
- op 7: result 0, dbz_o=0.
- Signed overflow (DIV or REM with a_i = most-negative value and b_i = -1): DIV gives a_i, REM gives 0.
REQ-024 In DONE, res_valid_o=1, and res_o, tag_o and dbz_o SHALL hold stable until the edge where res_ready_i=1; that edge returns the FSM to IDLE.
REQ-025 No new request SHALL be accepted in the cycle the result is consumed; the earliest new accept is the following edge.
REQ-026 flush_i=1 on an edge SHALL force IDLE and clear res_valid_o and dbz_o from any state, and SHALL take priority over accept and consume.
REQ-027 While flush_i=1, req_ready_o SHALL be 0.
REQ-028 res_valid_o SHALL be 0 in every state other than DONE.
REQ-029 Inputs a_i, b_i, op_i and tag_i SHALL be ignored outside the accept edge.

Reset
REQ-030 rst_ni=0 SHALL immediately and asynchronously force IDLE, with res_valid_o=0, dbz_o=0, res_o=0 and tag_o=0.
REQ-031 req_ready_o SHALL be 0 while rst_ni=0 and SHALL become 1 in the first cycle after release; this applies equally to reset asserted mid-CALC.

Verification (WID=80)
REQ-032 MUL a=7, b=6, tag=3, res_ready_i=1 -> res_valid_o on the 82nd edge after accept, res_o=42, tag_o=3, dbz_o=0.
REQ-033 DIV a=-7, b=2 -> res_o=-3; REM with the same operands -> res_o=-1; MULHU a=all ones, b=2 -> res_o=1.
REQ-034 DIVU a=9, b=0 -> res_valid_o one cycle after accept, res_o=all ones, dbz_o=1; DIV a=0x8000_0000_0000_0000_0000, b=-1 -> res_o=a, dbz_o=0.
REQ-035 Hold res_ready_i=0 for 10 cycles in DONE -> res_o, tag_o and res_valid_o stay constant and req_ready_o stays 0; raise res_ready_i -> IDLE next edge.
REQ-036 Pulse flush_i at CALC cycle 40 -> IDLE on that edge, no result produced; a following MUL 3*5 returns 15 with its own tag.
REQ-037 Drive rst_ni low mid-CALC -> outputs clear with no clock edge needed; after release, req_ready_o=1 and a new DIVU 100/7 gives 14.
